imem_loader: RTL
================

# imem_loader

Boot-time program loader that writes the instruction memory read by the fetch stage, over a byte-stream valid/ready link fed by a UART receiver or debug bridge. It parses a framed image (sync, length, little-endian words, checksum) and writes one word per write-port pulse. It holds the core in reset (`core_hold`) until an image is accepted. It sits beside `cpu_core` and drives the instruction memory's write port.

## Interface
- `WORD_SIZE`, 32, instruction word width; must be 32 (4 bytes per word)
- `NUM_WORDS`, 1024, instruction memory depth in words
- `ADDR_SIZE`, `$clog2(NUM_WORDS)`, word address width
- `SYNC_BYTE`, 8'hA5, frame start marker

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `rx_data`  in  8  incoming byte
- `rx_valid`  in  1  `rx_data` is valid
- `rx_ready`  out  1  loader can accept a byte. A byte transfers on an edge where `rx_valid & rx_ready`.
- `imem_we`  out  1  instruction memory write strobe, one-cycle pulse
- `imem_addr`  out  ADDR_SIZE  word address of the write
- `imem_wdata`  out  WORD_SIZE  word to write
- `core_hold`  out  1  keep the core in reset
- `load_done`  out  1  sticky: last frame accepted
- `load_error`  out  1  sticky: last frame rejected
- `words_loaded`  out  ADDR_SIZE+1  words written by the current or last frame

## Operation
- Frame format: `SYNC_BYTE`, `LEN_LO`, `LEN_HI`, then 4·N data bytes, then `CKSUM`.
  - N is the 16-bit word count.
  - Data bytes are little-endian: the first byte lands in bits [7:0].
  - `CKSUM` is the 8-bit sum, mod 256, of all data bytes.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK.
- IDLE:
  - A byte equal to `SYNC_BYTE` → LEN_LO. This also clears `load_done`, `load_error`, `words_loaded`, the byte counter, the checksum accumulator and the address, and sets `core_hold` = 1.
  - Any other byte is discarded.
- LEN_LO: latch the low byte of N → LEN_HI.
- LEN_HI: latch the high byte of N.
  - If N > `NUM_WORDS`: set `load_error`, → IDLE, no writes.
  - If N == 0: → CHECK.
  - Otherwise → DATA.
- DATA:
  - Shift each byte into the word assembly register and add it to the checksum.
  - On the 4th byte → WRITE.
- WRITE (exactly one cycle):
  - `imem_we` = 1, `imem_addr` = current address, `imem_wdata` = assembled word.
  - Address and `words_loaded` increment.
  - If `words_loaded` (after increment) == N → CHECK, else → DATA.
- CHECK: accept one byte, then → IDLE.
  - Byte equals the accumulator: `load_done` = 1 and `core_hold` = 0.
  - Otherwise: `load_error` = 1 and `core_hold` stays 1.
- Address arithmetic: `ADDR_SIZE` bits. The address never wraps, because N ≤ `NUM_WORDS` is enforced before any write.
- Rejected frames: memory already written is not erased, and the core stays held.
- A new `SYNC_BYTE` in IDLE after `load_done` starts a fresh load and re-asserts `core_hold`.
- Bytes equal to `SYNC_BYTE` inside LEN or DATA are payload, not resync.

## Timing
- Reset values: `rx_ready` 0, `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `core_hold` 1, `load_done` 0, `load_error` 0, `words_loaded` 0, state IDLE.
- `rx_ready` is registered.
  - It rises at the first edge after `rst` deasserts.
  - It is 0 exactly during the WRITE cycle and 1 in every other state.
- Write latency: if the 4th data byte transfers at edge k, then `imem_we` is high from edge k through k+1, and the next byte can transfer at edge k+2.
- Sustained throughput: 4 bytes per 5 cycles with `rx_valid` held high.
- `imem_we` is never high for two consecutive cycles.
- `core_hold` deasserts and `load_done` asserts on the same edge that accepts a matching `CKSUM`.
- `load_error` for an oversize N asserts on the edge that accepts `LEN_HI`.
- `rx_valid` low: no state change. The FSM waits indefinitely; there is no timeout.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronously). The next frame starts at address 0.

## Test plan
- Load two words. Bytes: A5 02 00 78 56 34 12 EF BE AD DE 4C.
  - Expect writes addr 0 = 0x12345678 and addr 1 = 0xDEADBEEF.
  - Then `load_done` = 1, `core_hold` = 0, `words_loaded` = 2.
- Same frame with checksum 4D.
  - Expect the same two writes, then `load_error` = 1, `load_done` = 0, `core_hold` = 1.
- Oversize length. Bytes: A5 01 04 (N = 1025, `NUM_WORDS` = 1024).
  - Expect `load_error` = 1 at the `LEN_HI` edge, no `imem_we`, IDLE.
  - Then a following valid frame loads correctly.
- Noise before sync, then an empty frame. Bytes: 00 FF A5 00 00 00.
  - Expect noise ignored, zero writes, `load_done` = 1, `core_hold` = 0.
- Back-to-back. Hold `rx_valid` = 1 through a 3-word frame.
  - Expect `rx_ready` low for exactly one cycle after each 4th byte.
  - Expect no byte lost or duplicated, and 3 single-cycle `imem_we` pulses.
- Reset mid-frame. Assert `rst` = 0 after 2 data bytes.
  - Expect all outputs at reset values, with `core_hold` = 1.
  - After release, a full frame writes starting at addr 0.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader.
// Parses a framed byte stream (sync, 16-bit word count, little-endian data
// words, 8-bit additive checksum) and writes each assembled word into the
// instruction memory. Holds the core in reset until a frame is accepted.
//
// state  | meaning
// IDLE   | waiting for SYNC_BYTE, other bytes dropped
// LEN_LO | expecting low byte of word count
// LEN_HI | expecting high byte, range check of word count
// DATA   | collecting 4 bytes of the next word
// WRITE  | single-cycle memory write, byte link stalled
// CHECK  | expecting checksum byte
module imem_loader #(
    parameter int          WORD_SIZE = 32,
    parameter int          NUM_WORDS = 1024,
    parameter int          ADDR_SIZE = $clog2(NUM_WORDS),
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic                 imem_we,
    output logic [ADDR_SIZE-1:0] imem_addr,
    output logic [WORD_SIZE-1:0] imem_wdata,
    output logic                 core_hold,
    output logic                 load_done,
    output logic                 load_error,
    output logic [ADDR_SIZE:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_CHECK  = 3'd5
    } state_t;

    localparam logic [31:0]          MAX_LEN  = NUM_WORDS;
    localparam logic [ADDR_SIZE-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_SIZE:0]   CNT_ONE  = 1;

    state_t                 state_q, state_d;
    logic [15:0]            len_q, len_d;
    logic [ADDR_SIZE-1:0]   addr_q, addr_d;
    logic [ADDR_SIZE:0]     words_q, words_d;
    logic [WORD_SIZE-1:0]   word_q, word_d;
    logic [1:0]             byte_cnt_q, byte_cnt_d;
    logic [7:0]             cksum_q, cksum_d;
    logic                   rx_ready_q, rx_ready_d;
    logic                   we_q, we_d;
    logic                   hold_q, hold_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic                   xfer;
    logic [15:0]            len_full;
    logic [ADDR_SIZE:0]     words_inc;

    assign xfer      = rx_valid & rx_ready_q;
    assign len_full  = {rx_data, len_q[7:0]};
    assign words_inc = words_q + CNT_ONE;

    assign rx_ready     = rx_ready_q;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = word_q;
    assign core_hold    = hold_q;
    assign load_done    = done_q;
    assign load_error   = err_q;
    assign words_loaded = words_q;

    // State and datapath registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            addr_q     <= '0;
            words_q    <= '0;
            word_q     <= '0;
            byte_cnt_q <= '0;
            cksum_q    <= '0;
            rx_ready_q <= 1'b0;
            we_q       <= 1'b0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            words_q    <= words_d;
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
            cksum_q    <= cksum_d;
            rx_ready_q <= rx_ready_d;
            we_q       <= we_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Frame parser: next state, datapath updates and registered strobes.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        addr_d     = addr_q;
        words_d    = words_q;
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        cksum_d    = cksum_q;
        hold_d     = hold_q;
        done_d     = done_q;
        err_d      = err_q;
        we_d       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (xfer && rx_data == SYNC_BYTE) begin
                    state_d    = S_LEN_LO;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    words_d    = '0;
                    byte_cnt_d = '0;
                    cksum_d    = '0;
                    addr_d     = '0;
                    hold_d     = 1'b1;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d   = {len_q[15:8], rx_data};
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_d = len_full;
                    if (32'(len_full) > MAX_LEN) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    // Shift right so the first byte of the word ends up in [7:0].
                    word_d     = {rx_data, word_q[WORD_SIZE-1:8]};
                    cksum_d    = cksum_q + rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + ADDR_ONE;
                words_d = words_inc;
                if (32'(words_inc) == 32'(len_q)) begin
                    state_d = S_CHECK;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CHECK: begin
                if (xfer) begin
                    state_d = S_IDLE;
                    if (rx_data == cksum_q) begin
                        done_d = 1'b1;
                        hold_d = 1'b0;
                    end else begin
                        err_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The byte link stalls only while the write cycle is in progress.
    always_comb begin
        rx_ready_d = (state_d != S_WRITE);
    end

endmodule
